// File: rtl/ft245_rx_reader.sv
// FT245 receive engine: synchronises _rxf, strobes _rd, samples d_in and queues
// each byte in a small first-word-fall-through buffer drained by valid/ready.
//
// state   | meaning
// IDLE    | _rd high, waiting for rxf_s low with buffer space
// STROBE  | _rd low; d_in captured on the last cycle
// RECOVER | _rd high hold-off; rxf_s ignored
module ft245_rx_reader #(
    parameter int RD_PULSE   = 3,
    parameter int RD_RECOVER = 2,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              _rxf,
    output logic              _rd,
    input  logic [7:0]        d_in,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [ADDR_W:0]   level,
    output logic              busy
);
    localparam int CNT_MAX = ((RD_PULSE > RD_RECOVER) ? RD_PULSE : RD_RECOVER) - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                rd_q, rd_nxt;
    logic                rxf_meta, rxf_s;
    logic                push, pop, full;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wptr, rptr;

    assign full     = (level == (ADDR_W + 1)'(DEPTH));
    assign rx_valid = (level != '0);
    assign pop      = rx_valid && rx_ready;
    assign rx_data  = mem[rptr];
    assign busy     = (state != IDLE);
    assign _rd      = rd_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = rd_q;
        push      = 1'b0;
        case (state)
            IDLE: begin
                rd_nxt = 1'b1;
                if (!rxf_s && !full) begin
                    rd_nxt    = 1'b0;
                    cnt_nxt   = CNT_W'(RD_PULSE - 1);
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                rd_nxt = 1'b0;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    push      = 1'b1;
                    rd_nxt    = 1'b1;
                    cnt_nxt   = CNT_W'(RD_RECOVER - 1);
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                rd_nxt = 1'b1;
                if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                else           state_nxt = IDLE;
            end
            default: begin
                rd_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_q     <= 1'b1;
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_q     <= rd_nxt;
            rxf_meta <= _rxf;
            rxf_s    <= rxf_meta;
        end
    end

    // Push and pop may coincide; level then holds while both pointers move.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (push) begin
                mem[wptr] <= d_in;
                wptr      <= wptr + ADDR_W'(1);
            end
            if (pop) rptr <= rptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule
